conv_feed_loader: RTL and testbench



---
 rtl/conv_feed_loader.sv | 240 ++++++++++++++++++++++++
 tb/tb_conv_feed_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_feed_loader.sv
// conv_feed_loader: reads KERNEL_SIZE^2 weights, then FM_SIZE^2 feature-map words,
// from one synchronous-read BRAM port and streams them into conv_blk.
// Optional feature macro: LOADER_HOLD_EN adds i_hold back-pressure with a 1-entry skid.
// Every word is presented two cycles after its address: BRAM latency plus an output register.

`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif
`ifndef FM_SIZE
`define FM_SIZE 5
`endif
`ifndef A_DSP_WIDTH
`define A_DSP_WIDTH 30
`endif

module conv_feed_loader #(
    parameter int KERNEL_SIZE = `KERNEL_SIZE,
    parameter int FM_SIZE     = `FM_SIZE,
    parameter int ADDR_W      = 12,
    parameter int WEIGHT_BASE = 0,
    parameter int FM_BASE     = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
`ifdef LOADER_HOLD_EN
    input  logic                           i_hold,
`endif
    output logic                           o_busy,
    output logic                           o_done,
    output logic [ADDR_W-1:0]              o_addr,
    input  logic [`A_DSP_WIDTH-1:0]        i_rdata,
    output logic                           o_weight_en,
    output logic signed [17:0]             o_weight_data,
    output logic                           o_go,
    output logic signed [`A_DSP_WIDTH-1:0] o_fm_data
);

    localparam int DW      = `A_DSP_WIDTH;
    localparam int W_COUNT = KERNEL_SIZE * KERNEL_SIZE;
    localparam int F_COUNT = FM_SIZE * FM_SIZE;
    localparam int WC_W    = $clog2(W_COUNT + 1);
    localparam int FC_W    = $clog2(F_COUNT + 1);

    typedef enum logic [1:0] {IDLE, RD_W, RD_FM, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic [WC_W-1:0]   w_cnt_reg, w_cnt_next;
    logic [FC_W-1:0]   f_cnt_reg, f_cnt_next;

    // Issue decode
    logic              issue;
    logic              issue_fm;
    logic [ADDR_W-1:0] issue_addr;
    logic              done_next;

    // Tag pipeline: stage 1 follows o_addr, stage 2 follows i_rdata
    logic              tag1_v_reg, tag1_fm_reg;
    logic              tag2_v_reg, tag2_fm_reg;

    // Word selected for presentation this cycle
    logic              pres_v;
    logic              pres_fm;
    logic [DW-1:0]     pres_data;

    logic              hold_act;
    logic              skid_pending;
    logic              drain_empty;

`ifdef LOADER_HOLD_EN
    logic              skid_v_reg;
    logic              skid_fm_reg;
    logic [DW-1:0]     skid_data_reg;

    // Hold is meaningless while idle, so a held i_hold never blocks a start
    assign hold_act     = i_hold && (state_reg != IDLE);
    assign skid_pending = skid_v_reg;
`else
    assign hold_act     = 1'b0;
    assign skid_pending = 1'b0;
`endif

    assign drain_empty = !hold_act && !tag1_v_reg && !tag2_v_reg && !skid_pending;

    // State and counter registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            w_cnt_reg <= '0;
            f_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            w_cnt_reg <= w_cnt_next;
            f_cnt_reg <= f_cnt_next;
        end
    end

    // Next-state logic; every non-idle transition is frozen while held
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_start) state_next = RD_W;
            RD_W:    if (!hold_act && w_cnt_reg == WC_W'(W_COUNT)) state_next = RD_FM;
            RD_FM:   if (!hold_act && f_cnt_reg == FC_W'(F_COUNT)) state_next = DRAIN;
            DRAIN:   if (drain_empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: which address to issue this cycle and how the counters advance
    always_comb begin
        issue      = 1'b0;
        issue_fm   = 1'b0;
        issue_addr = '0;
        w_cnt_next = w_cnt_reg;
        f_cnt_next = f_cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    issue      = 1'b1;
                    issue_addr = ADDR_W'(WEIGHT_BASE);
                    w_cnt_next = WC_W'(1);
                    f_cnt_next = '0;
                end
            end
            RD_W: begin
                if (!hold_act) begin
                    issue = 1'b1;
                    if (w_cnt_reg == WC_W'(W_COUNT)) begin
                        // First FM address follows the last weight with no gap
                        issue_fm   = 1'b1;
                        issue_addr = ADDR_W'(FM_BASE);
                        f_cnt_next = FC_W'(1);
                    end else begin
                        issue_addr = ADDR_W'(WEIGHT_BASE) + ADDR_W'(w_cnt_reg);
                        w_cnt_next = w_cnt_reg + WC_W'(1);
                    end
                end
            end
            RD_FM: begin
                if (!hold_act && f_cnt_reg != FC_W'(F_COUNT)) begin
                    issue      = 1'b1;
                    issue_fm   = 1'b1;
                    issue_addr = ADDR_W'(FM_BASE) + ADDR_W'(f_cnt_reg);
                    f_cnt_next = f_cnt_reg + FC_W'(1);
                end
            end
            DRAIN:   done_next = drain_empty;
            default: done_next = 1'b0;
        endcase
    end

    // Address register and read-tag pipeline; while held, o_addr stays put so the
    // BRAM keeps returning the stage-1 word, and stage 2 empties into the skid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_addr      <= '0;
            tag1_v_reg  <= 1'b0;
            tag1_fm_reg <= 1'b0;
            tag2_v_reg  <= 1'b0;
            tag2_fm_reg <= 1'b0;
        end else begin
            if (issue) begin
                o_addr <= issue_addr;
            end
            if (hold_act) begin
                tag2_v_reg <= 1'b0;
            end else begin
                tag1_v_reg  <= issue;
                tag1_fm_reg <= issue_fm;
                tag2_v_reg  <= tag1_v_reg;
                tag2_fm_reg <= tag1_fm_reg;
            end
        end
    end

    // Presentation source: a parked skid word always goes out before live data
    always_comb begin
`ifdef LOADER_HOLD_EN
        pres_v    = !hold_act && (skid_v_reg || tag2_v_reg);
        pres_fm   = skid_v_reg ? skid_fm_reg : tag2_fm_reg;
        pres_data = skid_v_reg ? skid_data_reg : i_rdata;
`else
        pres_v    = tag2_v_reg;
        pres_fm   = tag2_fm_reg;
        pres_data = i_rdata;
`endif
    end

`ifdef LOADER_HOLD_EN
    // Skid register: parks the word that returns from BRAM on the first held cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            skid_v_reg    <= 1'b0;
            skid_fm_reg   <= 1'b0;
            skid_data_reg <= '0;
        end else if (hold_act) begin
            if (tag2_v_reg) begin
                skid_v_reg    <= 1'b1;
                skid_fm_reg   <= tag2_fm_reg;
                skid_data_reg <= i_rdata;
            end
        end else begin
            skid_v_reg <= 1'b0;
        end
    end
`endif

    // Output registers: one-cycle strobes, data held between strobes, busy/done flags
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_weight_en   <= 1'b0;
            o_weight_data <= '0;
            o_go          <= 1'b0;
            o_fm_data     <= '0;
            o_done        <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_weight_en <= 1'b0;
            o_go        <= 1'b0;
            o_done      <= done_next;
            if (pres_v) begin
                if (pres_fm) begin
                    o_go      <= 1'b1;
                    o_fm_data <= pres_data;
                end else begin
                    o_weight_en   <= 1'b1;
                    o_weight_data <= pres_data[17:0];
                end
            end
            if (state_reg == IDLE && i_start) begin
                o_busy <= 1'b1;
            end else if (o_done) begin
                o_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_feed_loader.sv
// tb_conv_feed_loader: checks conv_feed_loader against a closed-form timing model
// (every event at a fixed offset from the accepted start) over a BRAM model.

`timescale 1ns/1ps

`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif
`ifndef FM_SIZE
`define FM_SIZE 5
`endif
`ifndef A_DSP_WIDTH
`define A_DSP_WIDTH 30
`endif

module tb_conv_feed_loader;

    localparam int KS = 3;
    localparam int FS = 5;
    localparam int AW = 12;
    localparam int WB = 0;
    localparam int FB = 16;
    localparam int KK = KS * KS;
    localparam int FF = FS * FS;
    localparam int T  = KK + FF + 3;   // done cycle relative to the start cycle
    localparam int DW = `A_DSP_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
`ifdef LOADER_HOLD_EN
    logic          hold = 1'b0;
`endif
    logic          busy, done, wen, go;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic [17:0]   wdata;
    logic [DW-1:0] fmdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] obs_w [KK];
    logic [DW-1:0] obs_f [FF];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int            a;
        logic [DW-1:0] val;
        logic [DW-1:0] exp;
        bit            is_fm;
        string         nm;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    // Synchronous-read BRAM: data appears one cycle after the address
    always @(posedge clk) rdata <= mem[addr];

    conv_feed_loader #(
        .KERNEL_SIZE (KS),
        .FM_SIZE     (FS),
        .ADDR_W      (AW),
        .WEIGHT_BASE (WB),
        .FM_BASE     (FB)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
`ifdef LOADER_HOLD_EN
        .i_hold        (hold),
`endif
        .o_busy        (busy),
        .o_done        (done),
        .o_addr        (addr),
        .i_rdata       (rdata),
        .o_weight_en   (wen),
        .o_weight_data (wdata),
        .o_go          (go),
        .o_fm_data     (fmdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected outputs r cycles after the cycle in which start was accepted
    task automatic check_r(input int r);
        int wi;
        int fi;
        cmp("busy", busy, (r >= 1 && r <= T));
        cmp("done", done, (r == T));
        cmp("weight_en", wen, (r >= 3 && r <= KK + 2));
        cmp("go", go, (r >= KK + 3 && r <= KK + FF + 2));
        if (r >= 1 && r <= KK) cmp("addr_w", addr, WB + r - 1);
        else if (r > KK && r <= KK + FF) cmp("addr_fm", addr, FB + r - KK - 1);
        if (r >= 3 && r <= KK + 2) begin
            wi = WB + r - 3;
            cmp("weight_data", wdata, mem[wi][17:0]);
            obs_w[r - 3] = wdata;
        end
        if (r >= KK + 3 && r <= KK + FF + 2) begin
            fi = FB + r - KK - 3;
            cmp("fm_data", fmdata, mem[fi]);
            obs_f[r - KK - 3] = fmdata;
        end
    endtask

    task automatic check_zero(input string nm);
        cmp({nm, "_busy"}, busy, 0);
        cmp({nm, "_done"}, done, 0);
        cmp({nm, "_addr"}, addr, 0);
        cmp({nm, "_weight_en"}, wen, 0);
        cmp({nm, "_weight_data"}, wdata, 0);
        cmp({nm, "_go"}, go, 0);
        cmp({nm, "_fm_data"}, fmdata, 0);
    endtask

    // One complete load; noise re-pulses start while the loader is busy
    task automatic run_load(input int pre_gap, input bit noise, input int id);
        for (int i = 0; i < pre_gap; i++) begin
            check_r(-1);
            step();
        end
        start = 1'b1;
        check_r(0);
        step();
        start = 1'b0;
        for (int r = 1; r <= T + 1; r++) begin
            start = noise && (r <= T - 1) && ($urandom_range(0, 3) == 0);
            check_r(r);
            step();
        end
        start = 1'b0;
        $display("load %0d: %0d weights + %0d fm words, done expected at +%0d", id, KK, FF, T);
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a + 1);

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_zero("reset");

        // Basic load with mem[a]=a+1
        run_load(1, 1'b0, 1);

        // Start re-pulsed at +5 and +20 is ignored
        start = 1'b1;
        check_r(0);
        step();
        start = 1'b0;
        for (int r = 1; r <= T + 1; r++) begin
            start = (r == 5 || r == 20);
            check_r(r);
            step();
        end
        start = 1'b0;
        $display("load 2: start re-pulsed at +5 and +20");

        // Reset at +15 aborts; restart at +20 reproduces the basic timing
        start = 1'b1;
        check_r(0);
        step();
        start = 1'b0;
        for (int r = 1; r <= 15; r++) begin
            rst = (r == 15);
            check_r(r);
            step();
        end
        rst = 1'b0;
        check_zero("abort");
        step();
        run_load(3, 1'b0, 3);

        // Width / sign table
        tbl[0] = '{0,  30'h3FFF_FFFF, 30'h0003_FFFF, 1'b0, "w_all_ones"};
        tbl[1] = '{1,  30'h0003_FFFF, 30'h0003_FFFF, 1'b0, "w_exact_18"};
        tbl[2] = '{4,  30'h1234_5678, 30'h0000_5678, 1'b0, "w_truncate"};
        tbl[3] = '{8,  30'h2002_0001, 30'h0002_0001, 1'b0, "w_bit17"};
        tbl[4] = '{16, 30'h2000_0000, 30'h2000_0000, 1'b1, "fm_negative"};
        tbl[5] = '{28, 30'h0000_0001, 30'h0000_0001, 1'b1, "fm_one"};
        tbl[6] = '{40, 30'h3FFF_FFFF, 30'h3FFF_FFFF, 1'b1, "fm_all_ones"};
        for (int i = 0; i < 7; i++) mem[tbl[i].a] = tbl[i].val;
        run_load(2, 1'b0, 4);
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].is_fm) cmp(tbl[i].nm, obs_f[tbl[i].a - FB], tbl[i].exp);
            else cmp(tbl[i].nm, obs_w[tbl[i].a - WB], tbl[i].exp);
        end
        // Data registers hold the last word once their strobe is low
        cmp("weight_hold", wdata, 30'h0002_0001);
        cmp("fm_hold", fmdata, 30'h3FFF_FFFF);

        // Randomized contents, gaps and stray start pulses
        for (int k = 0; k < 8; k++) begin
            for (int a = WB; a < WB + KK; a++) mem[a] = DW'($urandom);
            for (int a = FB; a < FB + FF; a++) mem[a] = DW'($urandom);
            run_load($urandom_range(0, 3), 1'b1, 5 + k);
        end

`ifdef LOADER_HOLD_EN
        begin
            logic [DW-1:0] fq[$];
            logic [DW-1:0] wq[$];
            int            done_at;
            for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a + 1);
            done_at = -1;
            step();
            for (int r = 0; r <= T + 6; r++) begin
                start = (r == 0);
                hold  = (r >= 14 && r <= 17);
                if (go) fq.push_back(fmdata);
                if (wen) wq.push_back(DW'(wdata));
                if (r >= 15 && r <= 18) cmp("hold_go_low", go, 0);
                if (done && done_at < 0) done_at = r;
                step();
            end
            start = 1'b0;
            hold  = 1'b0;
            cmp("hold_fm_count", fq.size(), FF);
            cmp("hold_w_count", wq.size(), KK);
            for (int j = 0; j < fq.size() && j < FF; j++) cmp("hold_fm_seq", fq[j], FB + j + 1);
            for (int j = 0; j < wq.size() && j < KK; j++) cmp("hold_w_seq", wq[j], WB + j + 1);
            cmp("hold_done_cycle", done_at, 41);
            cmp("hold_busy_end", busy, 0);
            $display("load hold: i_hold over +14..+17, done expected at +41");
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
